// File: rtl/axi_burst_splitter_r_merge_pkg.sv
// Shared definitions for the burst splitter R-merge stage: AXI response codes,
// output buffer occupancy states and the error-response classifier.
package axi_burst_splitter_r_merge_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      FILL_EMPTY = 2'd0,
      FILL_ONE   = 2'd1,
      FILL_FULL  = 2'd2
   } fill_e;

   // SLVERR and DECERR both poison the burst; OKAY and EXOKAY do not.
   function automatic logic isErrResp(input logic [1:0] resp);
      logic isErr;
      case (resp)
         RESP_SLVERR, RESP_DECERR: isErr = 1'b1;
         RESP_OKAY, RESP_EXOKAY:   isErr = 1'b0;
         default:                  isErr = 1'b0;
      endcase
      return isErr;
   endfunction

endpackage

// File: rtl/axi_burst_splitter_r_buf.sv
// Generic 2-entry ready-decoupled buffer: A is the head, B the overflow slot.
// o_canPush depends only on registered occupancy, never on i_ready.
module axi_burst_splitter_r_buf
   import axi_burst_splitter_r_merge_pkg::*;
#(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] i_data,
   input  logic             i_push,
   output logic             o_canPush,
   output logic [Width-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready
);

   fill_e            r_fill;
   logic [Width-1:0] r_a;
   logic [Width-1:0] r_b;
   logic             w_push;
   logic             w_pop;

   assign o_canPush = (r_fill != FILL_FULL);
   assign o_valid   = (r_fill != FILL_EMPTY);
   assign o_data    = r_a;
   assign w_push    = i_push & o_canPush;
   assign w_pop     = o_valid & i_ready;

   // When full, a pop only shifts B into A; the freed slot is usable next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fill <= FILL_EMPTY;
         r_a    <= '0;
         r_b    <= '0;
      end else begin
         case (r_fill)
            FILL_EMPTY: begin
               if (w_push) begin
                  r_a    <= i_data;
                  r_fill <= FILL_ONE;
               end
            end
            FILL_ONE: begin
               if (w_push && w_pop) begin
                  r_a <= i_data;
               end else if (w_push) begin
                  r_b    <= i_data;
                  r_fill <= FILL_FULL;
               end else if (w_pop) begin
                  r_fill <= FILL_EMPTY;
               end
            end
            FILL_FULL: begin
               if (w_pop) begin
                  r_a    <= r_b;
                  r_fill <= FILL_ONE;
               end
            end
            default: r_fill <= FILL_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/axi_burst_splitter_r_merge.sv
// R-merge stage of the burst splitter: regenerates RLAST on single-beat
// responses from the per-ID counter and re-times them through a 2-entry buffer.
module axi_burst_splitter_r_merge
   import axi_burst_splitter_r_merge_pkg::*;
#(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned UserWidth = 2
) (
   input  logic                                       clk_i,
   input  logic                                       rst_ni,
   input  logic [IdWidth+DataWidth+3+UserWidth-1:0]   r_i,
   input  logic                                       r_valid_i,
   output logic                                       r_ready_o,
   output logic [IdWidth+DataWidth+3+UserWidth-1:0]   r_o,
   output logic                                       r_valid_o,
   input  logic                                       r_ready_i,
   output logic [IdWidth-1:0]                         cnt_id_o,
   input  logic [7:0]                                 cnt_len_i,
   output logic                                       cnt_set_err_o,
   input  logic                                       cnt_err_i,
   output logic                                       cnt_dec_o,
   output logic                                       cnt_req_o,
   input  logic                                       cnt_gnt_i
);

   localparam int unsigned Width   = IdWidth + DataWidth + 3 + UserWidth;
   localparam int unsigned LastBit = UserWidth;
   localparam int unsigned RespLo  = UserWidth + 1;

   logic             w_canPush;
   logic [Width-1:0] w_beat;
   logic             w_unusedErr;

   // The sticky error is only consumed on the write side.
   assign w_unusedErr = cnt_err_i;

   assign cnt_id_o      = r_i[Width-1 -: IdWidth];
   assign cnt_req_o     = r_valid_i & w_canPush;
   assign r_ready_o     = cnt_gnt_i & w_canPush;
   assign cnt_dec_o     = r_valid_i & r_ready_o;
   assign cnt_set_err_o = cnt_dec_o & isErrResp(r_i[RespLo +: 2]);

   // Downstream last is always 1; the real last comes from the remaining count.
   always_comb begin
      w_beat          = r_i;
      w_beat[LastBit] = (cnt_len_i == 8'd0);
   end

   axi_burst_splitter_r_buf #(
      .Width(Width)
   ) u_buf (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .i_data   (w_beat),
      .i_push   (cnt_dec_o),
      .o_canPush(w_canPush),
      .o_data   (r_o),
      .o_valid  (r_valid_o),
      .i_ready  (r_ready_i)
   );

   downstreamLastSet: assert property (
      @(posedge clk_i) disable iff (!rst_ni) r_valid_i |-> r_i[LastBit]
   );

endmodule

// File: tb/tb_axi_burst_splitter_r_merge.sv
// Directed bench for the R-merge stage: a queue model of the upstream beats is
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_axi_burst_splitter_r_merge;

   localparam int IW = 4;
   localparam int DW = 16;
   localparam int UW = 2;
   localparam int W  = IW + DW + 3 + UW;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [W-1:0]  r_i = '0;
   logic          r_valid_i = 1'b0;
   logic          r_ready_o;
   logic [W-1:0]  r_o;
   logic          r_valid_o;
   logic          r_ready_i = 1'b0;
   logic [IW-1:0] cnt_id_o;
   logic [7:0]    cnt_len_i = 8'd0;
   logic          cnt_set_err_o;
   logic          cnt_err_i = 1'b0;
   logic          cnt_dec_o;
   logic          cnt_req_o;
   logic          cnt_gnt_i = 1'b0;

   int checks = 0;
   int errors = 0;
   int acceptCount = 0;
   int decCount = 0;
   int errCount = 0;
   logic [W-1:0] expQ[$];
   logic [W-1:0] outLog[$];

   axi_burst_splitter_r_merge #(
      .IdWidth  (IW),
      .DataWidth(DW),
      .UserWidth(UW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .r_i          (r_i),
      .r_valid_i    (r_valid_i),
      .r_ready_o    (r_ready_o),
      .r_o          (r_o),
      .r_valid_o    (r_valid_o),
      .r_ready_i    (r_ready_i),
      .cnt_id_o     (cnt_id_o),
      .cnt_len_i    (cnt_len_i),
      .cnt_set_err_o(cnt_set_err_o),
      .cnt_err_i    (cnt_err_i),
      .cnt_dec_o    (cnt_dec_o),
      .cnt_req_o    (cnt_req_o),
      .cnt_gnt_i    (cnt_gnt_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] mkBeat(input logic [IW-1:0] id, input logic [DW-1:0] data,
                                           input logic [1:0] resp);
      return {id, data, resp, 1'b1, data[UW-1:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one downstream beat and hold it until the model sees it accepted.
   task automatic applyStimulus(input logic [IW-1:0] id, input logic [DW-1:0] data,
                                input logic [1:0] resp, input logic [7:0] len, output int waits);
      int prev;
      r_i       = mkBeat(id, data, resp);
      cnt_len_i = len;
      r_valid_i = 1'b1;
      prev      = acceptCount;
      waits     = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk_i);
         #1;
         waits++;
         if (acceptCount != prev) break;
      end
      checkOutput("accepted", acceptCount - prev, 1);
   endtask

   task automatic drain();
      r_valid_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (expQ.size() == 0) break;
         @(posedge clk_i);
         #1;
      end
      checkOutput("drain", expQ.size(), 0);
   endtask

   // Model: one beat per accepted downstream beat, last set when no beats remain.
   always @(posedge clk_i) begin : model
      int sz;
      logic [W-1:0] b;
      if (rst_ni) begin
         sz = expQ.size();
         if (sz > 0 && r_ready_i) begin
            outLog.push_back(expQ[0]);
            void'(expQ.pop_front());
         end
         if (r_valid_i && cnt_gnt_i && sz < 2) begin
            b     = r_i;
            b[UW] = (cnt_len_i == 8'd0);
            expQ.push_back(b);
            acceptCount++;
         end
      end
   end

   always @(negedge clk_i) begin : compare
      int sz;
      logic expDec;
      if (rst_ni) begin
         sz     = expQ.size();
         expDec = r_valid_i && cnt_gnt_i && sz < 2;
         checkOutput("r_ready_o", r_ready_o, cnt_gnt_i && sz < 2);
         checkOutput("cnt_req_o", cnt_req_o, r_valid_i && sz < 2);
         checkOutput("cnt_dec_o", cnt_dec_o, expDec);
         checkOutput("cnt_set_err_o", cnt_set_err_o, expDec && r_i[UW+2]);
         checkOutput("cnt_id_o", cnt_id_o, r_i[W-1 -: IW]);
         checkOutput("r_valid_o", r_valid_o, sz > 0);
         if (sz > 0) checkOutput("r_o", r_o, expQ[0]);
         if (cnt_dec_o) decCount++;
         if (cnt_set_err_o) errCount++;
      end
   end

   initial begin
      int w;
      int base;
      int lasts;
      logic [3:0] lastPat;
      logic [3:0] idPat [4];
      logic [1:0] respPat [3];

      #1;
      checkOutput("reset_r_valid_o", r_valid_o, 0);
      checkOutput("reset_r_o", r_o, 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni    = 1'b1;
      r_ready_i = 1'b1;
      cnt_gnt_i = 1'b1;

      $display("[TB] 4-beat burst on ID 3");
      outLog.delete();
      base    = decCount;
      lastPat = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'd3, 16'(16'h1000 + i), 2'b00, 8'(3 - i), w);
         checkOutput("burst_throughput", w, 1);
      end
      drain();
      checkOutput("burst_beats", outLog.size(), 4);
      for (int i = 0; i < 4 && i < outLog.size(); i++)
         checkOutput("burst_last", outLog[i][UW], lastPat[i]);
      checkOutput("burst_decs", decCount - base, 4);

      $display("[TB] interleaved single-beat bursts on IDs 1 and 2");
      outLog.delete();
      idPat = '{4'd1, 4'd2, 4'd1, 4'd2};
      for (int i = 0; i < 4; i++)
         applyStimulus(idPat[i], 16'(16'h2000 + i), 2'b00, 8'd0, w);
      drain();
      checkOutput("interleave_beats", outLog.size(), 4);
      for (int i = 0; i < 4 && i < outLog.size(); i++) begin
         checkOutput("interleave_last", outLog[i][UW], 1);
         checkOutput("interleave_id", outLog[i][W-1 -: IW], idPat[i]);
      end

      $display("[TB] SLVERR on beat 2 of 3");
      outLog.delete();
      base    = errCount;
      respPat = '{2'b00, 2'b10, 2'b00};
      for (int i = 0; i < 3; i++)
         applyStimulus(4'd5, 16'(16'h3000 + i), respPat[i], 8'(2 - i), w);
      drain();
      checkOutput("slverr_pulses", errCount - base, 1);
      checkOutput("slverr_beats", outLog.size(), 3);
      for (int i = 0; i < 3 && i < outLog.size(); i++)
         checkOutput("slverr_resp", outLog[i][UW+2:UW+1], respPat[i]);

      $display("[TB] upstream stall for 5 cycles");
      outLog.delete();
      r_ready_i = 1'b0;
      base      = acceptCount;
      fork
         begin
            int ws;
            for (int i = 0; i < 4; i++)
               applyStimulus(4'd6, 16'(16'h4000 + i), 2'b00, 8'(3 - i), ws);
         end
         begin
            repeat (5) @(posedge clk_i);
            #1;
            checkOutput("stall_accepts", acceptCount - base, 2);
            checkOutput("stall_r_ready_o", r_ready_o, 0);
            checkOutput("stall_cnt_req_o", cnt_req_o, 0);
            r_ready_i = 1'b1;
         end
      join
      drain();
      checkOutput("stall_beats", outLog.size(), 4);
      for (int i = 0; i < 4 && i < outLog.size(); i++)
         checkOutput("stall_data", outLog[i][UW+3 +: DW], 16'h4000 + i);

      $display("[TB] grant withheld for 3 cycles");
      outLog.delete();
      cnt_gnt_i = 1'b0;
      base      = decCount;
      fork
         applyStimulus(4'd8, 16'h5000, 2'b00, 8'd0, w);
         begin
            repeat (3) @(posedge clk_i);
            #1;
            checkOutput("nogrant_decs", decCount - base, 0);
            cnt_gnt_i = 1'b1;
         end
      join
      checkOutput("nogrant_wait", w, 4);
      drain();
      checkOutput("nogrant_beats", outLog.size(), 1);
      if (outLog.size() > 0) checkOutput("nogrant_data", outLog[0][UW+3 +: DW], 16'h5000);

      $display("[TB] reset with two beats buffered");
      r_ready_i = 1'b0;
      applyStimulus(4'd7, 16'h6000, 2'b00, 8'd1, w);
      applyStimulus(4'd7, 16'h6001, 2'b00, 8'd0, w);
      r_valid_i = 1'b0;
      checkOutput("prereset_r_valid_o", r_valid_o, 1);
      rst_ni = 1'b0;
      expQ.delete();
      #1;
      checkOutput("midreset_r_valid_o", r_valid_o, 0);
      checkOutput("midreset_r_o", r_o, 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni    = 1'b1;
      r_ready_i = 1'b1;

      $display("[TB] 256-beat burst after reset");
      outLog.delete();
      for (int i = 0; i < 256; i++)
         applyStimulus(4'd9, 16'(i), 2'b00, 8'(255 - i), w);
      drain();
      checkOutput("long_beats", outLog.size(), 256);
      lasts = 0;
      foreach (outLog[i]) if (outLog[i][UW]) lasts++;
      checkOutput("long_last_count", lasts, 1);
      if (outLog.size() == 256) checkOutput("long_last_final", outLog[255][UW], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
